// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, FU indices and result types for the writeback path.
package cpu_pkg;
    localparam int DATA_W     = 32;
    localparam int PREG_W     = 6;
    localparam int ROB_W      = 6;
    localparam int NUM_FU     = 4;
    localparam int FIFO_DEPTH = 2;
    localparam int SRC_W      = $clog2(NUM_FU);
    localparam int FU_ALU0    = 0;
    localparam int FU_ALU1    = 1;
    localparam int FU_ALU2    = 2;
    localparam int FU_LSU     = 3;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [PREG_W-1:0] preg;
        logic [ROB_W-1:0]  rob;
    } fu_result_t;

    // Returns {found, index} of the first requester after `last`, wrapping.
    function automatic logic [SRC_W:0] rr_pick(input logic [NUM_FU-1:0] req,
                                                input logic [SRC_W-1:0] last);
        logic [SRC_W-1:0] idx;
        rr_pick = '0;
        for (int k = NUM_FU; k >= 1; k--) begin
            idx = SRC_W'((int'(last) + k) % NUM_FU);
            if (req[idx]) rr_pick = {1'b1, idx};
        end
    endfunction
endpackage

// File: rtl/fu_result_fifo.sv
// fu_result_fifo: small synchronous result FIFO with flush; full/empty come from the registered count.
module fu_result_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  fu_result_t din,
    output fu_result_t dout,
    output logic       full,
    output logic       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fu_result_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    assign full    = cnt_q == CNT_W'(DEPTH);
    assign empty   = cnt_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_W'(1);
            if (do_pop) rd_q <= rd_q + PTR_W'(1);
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers per-FU results and round-robin arbitrates them
// onto one registered common data bus.
module cdb_arbiter
    import cpu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic [NUM_FU-1:0]        fu_valid,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    input  logic [NUM_FU*PREG_W-1:0] fu_preg,
    input  logic [NUM_FU*ROB_W-1:0]  fu_rob,
    output logic [NUM_FU-1:0]        fu_ready,
    output logic                     cdb_valid,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [PREG_W-1:0]        cdb_preg,
    output logic [ROB_W-1:0]         cdb_rob,
    output logic [SRC_W-1:0]         cdb_src,
    input  logic                     cdb_ready
);
    fu_result_t        fu_in [NUM_FU];
    fu_result_t        head  [NUM_FU];
    logic [NUM_FU-1:0] full, empty, pop;
    logic [SRC_W-1:0]  last_q, last_d, win, src_q, src_d;
    logic              found, load_en, valid_q, valid_d;
    fu_result_t        cdb_q, cdb_d;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        assign fu_in[i] = '{data: fu_data[i*DATA_W +: DATA_W],
                            preg: fu_preg[i*PREG_W +: PREG_W],
                            rob:  fu_rob[i*ROB_W +: ROB_W]};
        fu_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rstn  (rstn),
            .flush (flush),
            .push  (fu_valid[i]),
            .pop   (pop[i]),
            .din   (fu_in[i]),
            .dout  (head[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    assign fu_ready = ~full;

    // Arbitration only advances when the CDB register can take a new value.
    always_comb begin
        load_en      = !valid_q || cdb_ready;
        {found, win} = rr_pick(~empty, last_q);
        pop          = (load_en && found) ? (NUM_FU'(1) << win) : '0;
        last_d       = (load_en && found) ? win : last_q;
        valid_d      = load_en ? found : valid_q;
        cdb_d        = (load_en && found) ? head[win] : cdb_q;
        src_d        = (load_en && found) ? win : src_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            valid_q <= 1'b0;
            cdb_q   <= '0;
            src_q   <= '0;
            last_q  <= SRC_W'(NUM_FU - 1);
        end else begin
            valid_q <= valid_d;
            cdb_q   <= cdb_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end

    assign cdb_valid = valid_q;
    assign cdb_data  = cdb_q.data;
    assign cdb_preg  = cdb_q.preg;
    assign cdb_rob   = cdb_q.rob;
    assign cdb_src   = src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus with an expected-broadcast queue
// checked by an independent CDB monitor.
module tb_cdb_arbiter;
    import cpu_pkg::*;

    logic                     clk = 1'b0, rstn = 1'b0, flush = 1'b0, cdb_ready = 1'b0;
    logic [NUM_FU-1:0]        fu_valid = '0, fu_ready;
    logic [NUM_FU*DATA_W-1:0] fu_data = '0;
    logic [NUM_FU*PREG_W-1:0] fu_preg = '0;
    logic [NUM_FU*ROB_W-1:0]  fu_rob = '0;
    logic                     cdb_valid;
    logic [DATA_W-1:0]        cdb_data;
    logic [PREG_W-1:0]        cdb_preg;
    logic [ROB_W-1:0]         cdb_rob;
    logic [SRC_W-1:0]         cdb_src;

    typedef struct packed {
        logic [SRC_W-1:0]  src;
        logic [DATA_W-1:0] data;
        logic [PREG_W-1:0] preg;
        logic [ROB_W-1:0]  rob;
    } bc_t;

    bc_t exp_q[$];
    bc_t st [NUM_FU][8];
    int  st_n [NUM_FU];
    int  st_i [NUM_FU];
    int  n_chk = 0, n_err = 0;
    bc_t cur, prev, e;
    bit  stall = 1'b0;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .fu_valid  (fu_valid),
        .fu_data   (fu_data),
        .fu_preg   (fu_preg),
        .fu_rob    (fu_rob),
        .fu_ready  (fu_ready),
        .cdb_valid (cdb_valid),
        .cdb_data  (cdb_data),
        .cdb_preg  (cdb_preg),
        .cdb_rob   (cdb_rob),
        .cdb_src   (cdb_src),
        .cdb_ready (cdb_ready)
    );

    // Monitor: every accepted broadcast must match the head of the expected queue,
    // and a stalled broadcast must not change.
    always @(negedge clk) begin
        cur = '{src: cdb_src, data: cdb_data, preg: cdb_preg, rob: cdb_rob};
        if (stall && cdb_valid) begin
            n_chk++;
            if (cur !== prev) begin
                n_err++;
                $display("FAIL cdb_hold: got %h, required %h", cur, prev);
            end
        end
        if (rstn && cdb_valid && cdb_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL cdb_unexpected: got src=%0d data=%h preg=%0d rob=%0d, required none",
                         cur.src, cur.data, cur.preg, cur.rob);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    n_err++;
                    $display("FAIL cdb_payload: got src=%0d data=%h preg=%0d rob=%0d, required src=%0d data=%h preg=%0d rob=%0d",
                             cur.src, cur.data, cur.preg, cur.rob, e.src, e.data, e.preg, e.rob);
                end
            end
        end
        stall = rstn && cdb_valid && !cdb_ready;
        prev  = cur;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        n_chk++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue a result for FU f; when ex is set, it is also expected on the CDB in call order.
    task automatic item(input int f, input logic [DATA_W-1:0] d, input logic [PREG_W-1:0] p,
                        input logic [ROB_W-1:0] r, input bit ex);
        st[f][st_n[f]] = '{src: SRC_W'(f), data: d, preg: p, rob: r};
        st_n[f]++;
        if (ex) exp_q.push_back('{src: SRC_W'(f), data: d, preg: p, rob: r});
    endtask

    function automatic bit pending();
        pending = 1'b0;
        for (int f = 0; f < NUM_FU; f++) if (st_i[f] < st_n[f]) pending = 1'b1;
    endfunction

    // Present queued results, holding each until the FU handshake completes.
    task automatic drive(input int budget);
        int cyc = 0;
        while (pending() && cyc < budget) begin
            for (int f = 0; f < NUM_FU; f++) begin
                fu_valid[f] = st_i[f] < st_n[f];
                if (fu_valid[f]) begin
                    fu_data[f*DATA_W +: DATA_W] = st[f][st_i[f]].data;
                    fu_preg[f*PREG_W +: PREG_W] = st[f][st_i[f]].preg;
                    fu_rob[f*ROB_W +: ROB_W]    = st[f][st_i[f]].rob;
                end
            end
            @(negedge clk);
            for (int f = 0; f < NUM_FU; f++) if (fu_valid[f] && fu_ready[f]) st_i[f]++;
            tick();
            cyc++;
        end
        fu_valid = '0;
        n_chk++;
        if (pending()) begin
            n_err++;
            $display("FAIL drive_timeout: got results still pending after %0d cycles, required none", budget);
        end
        for (int f = 0; f < NUM_FU; f++) begin
            st_n[f] = 0;
            st_i[f] = 0;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 64'(cdb_valid), 64'(0));
        chk({tag, "_data"}, 64'(cdb_data), 64'(0));
        chk({tag, "_preg"}, 64'(cdb_preg), 64'(0));
        chk({tag, "_rob"}, 64'(cdb_rob), 64'(0));
        chk({tag, "_src"}, 64'(cdb_src), 64'(0));
        chk({tag, "_ready"}, 64'(fu_ready), 64'(4'hf));
    endtask

    initial begin
        tick();
        tick();
        chk_reset("reset");
        rstn = 1'b1;

        // Single result: 2-edge latency, then idle.
        cdb_ready = 1'b1;
        item(FU_ALU1, 32'h0000_1234, 6'd5, 6'd9, 1'b1);
        drive(10);
        chk("single_lat_edge0", 64'(cdb_valid), 64'(0));
        tick();
        chk("single_valid", 64'(cdb_valid), 64'(1));
        chk("single_src", 64'(cdb_src), 64'(1));
        chk("single_data", 64'(cdb_data), 64'(32'h1234));
        tick();
        chk("single_idle", 64'(cdb_valid), 64'(0));

        // Four-way contention from a fresh pointer: 0,1,2,3; then 0 before 2 (preg 0 included).
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int f = 0; f < NUM_FU; f++)
            item(f, 32'hA0 + DATA_W'(f), PREG_W'(f + 1), ROB_W'(10 + f), 1'b1);
        drive(10);
        tick();
        chk("contend_first_src", 64'(cdb_src), 64'(0));
        repeat (4) tick();
        item(FU_ALU0, 32'hB0, 6'd7, 6'd20, 1'b1);
        item(FU_ALU2, 32'hB2, 6'd0, 6'd21, 1'b1);
        drive(10);
        tick();
        chk("wrap_src0", 64'(cdb_src), 64'(0));
        tick();
        chk("wrap_src2", 64'(cdb_src), 64'(2));
        chk("wrap_preg0", 64'(cdb_preg), 64'(0));
        tick();

        // Backpressure: CDB holds C0 while FIFO0 fills.
        cdb_ready = 1'b0;
        item(FU_ALU0, 32'hC0, 6'd8, 6'd30, 1'b1);
        item(FU_ALU0, 32'hC1, 6'd9, 6'd31, 1'b1);
        item(FU_ALU0, 32'hC2, 6'd10, 6'd32, 1'b1);
        drive(10);
        chk("bp_full_ready", 64'(fu_ready), 64'(4'b1110));
        chk("bp_hold_data", 64'(cdb_data), 64'(32'hC0));
        tick();
        chk("bp_full_ready2", 64'(fu_ready), 64'(4'b1110));
        chk("bp_hold_data2", 64'(cdb_data), 64'(32'hC0));
        cdb_ready = 1'b1;
        repeat (4) tick();

        // Fairness: FU0 and LSU streaming alternate 0,3,0,3,0,3.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            item(FU_ALU0, 32'hD0 + DATA_W'(k), PREG_W'(11 + k), ROB_W'(40 + k), 1'b1);
            item(FU_LSU, 32'hE0 + DATA_W'(k), PREG_W'(21 + k), ROB_W'(50 + k), 1'b1);
        end
        drive(20);
        repeat (4) tick();

        // Flush with 3 buffered entries and a live broadcast: nothing survives.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        cdb_ready = 1'b0;
        item(FU_ALU0, 32'hF0, 6'd1, 6'd1, 1'b0);
        item(FU_ALU0, 32'hF1, 6'd2, 6'd2, 1'b0);
        item(FU_ALU1, 32'hF2, 6'd3, 6'd3, 1'b0);
        item(FU_ALU1, 32'hF3, 6'd4, 6'd4, 1'b0);
        drive(10);
        chk("flush_pre_valid", 64'(cdb_valid), 64'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", 64'(cdb_valid), 64'(0));
        chk("flush_ready", 64'(fu_ready), 64'(4'hf));
        cdb_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("flush_no_stale", 64'(cdb_valid), 64'(0));
        end

        // Reset mid-operation with full FIFOs, then FU0-first priority.
        cdb_ready = 1'b0;
        for (int f = 0; f < NUM_FU; f++) begin
            item(f, 32'h5000 + DATA_W'(f), 6'd33, 6'd33, 1'b0);
            item(f, 32'h6000 + DATA_W'(f), 6'd34, 6'd34, 1'b0);
        end
        drive(10);
        chk("pre_reset_ready", 64'(fu_ready), 64'(4'b0001));
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk_reset("midreset");
        cdb_ready = 1'b1;
        item(FU_ALU0, 32'h7000, 6'd40, 6'd60, 1'b1);
        item(FU_LSU, 32'h7003, 6'd43, 6'd63, 1'b1);
        drive(10);
        chk("post_reset_lat", 64'(cdb_valid), 64'(0));
        tick();
        chk("post_reset_src0", 64'(cdb_src), 64'(0));
        tick();
        chk("post_reset_src3", 64'(cdb_src), 64'(3));
        repeat (2) tick();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
